// File: rtl/vga_timing_gen.sv
// Raster timing source: divided pixel strobe, DrawX/DrawY scan counters, delayed hs/vs/blank.
// Define VGA_FRAME_COUNT_EN to build the 16-bit frame_count counter; otherwise it reads 0.
module vga_timing_gen #(
    parameter int unsigned PIX_DIV    = 4,
    parameter int unsigned PIPE_DEPTH = 1,
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        pixel_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        active_nblank,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [2:0] DIV_MAX  = 3'(PIX_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Pipe stage layout {hs, vs, active}; idle is sync deasserted and blanked.
    localparam logic [2:0] PIPE_IDLE = 3'b110;

    logic [2:0] div_q;
    logic       pixel_en_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       line_start_q;
    logic       frame_start_q;
    logic [2:0] pipe_q [PIPE_DEPTH];
    logic       x_wrap;
    logic       y_wrap;
    logic       hs_raw;
    logic       vs_raw;
    logic       act_raw;

    always_comb begin
        x_wrap  = (x_q == H_MAX);
        y_wrap  = (y_q == V_MAX);
        hs_raw  = !((x_q >= HS_START) && (x_q < HS_END));
        vs_raw  = !((y_q >= VS_START) && (y_q < VS_END));
        act_raw = (x_q < H_VIS) && (y_q < V_VIS);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q      <= 3'd0;
            pixel_en_q <= 1'b0;
        end else begin
            div_q      <= (div_q == DIV_MAX) ? 3'd0 : div_q + 3'd1;
            pixel_en_q <= (div_q == DIV_MAX);
        end
    end

    // Wrap pulses are registered alongside the counter update so they coincide with (0,y)/(0,0).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= pixel_en_q && x_wrap;
            frame_start_q <= pixel_en_q && x_wrap && y_wrap;
            if (pixel_en_q) begin
                if (x_wrap) begin
                    x_q <= 10'd0;
                    y_q <= y_wrap ? 10'd0 : y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= PIPE_IDLE;
            end
        end else if (pixel_en_q) begin
            pipe_q[0] <= {hs_raw, vs_raw, act_raw};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_count_q <= 16'd0;
        end else if (frame_start_q) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = 16'd0;
`endif

    assign pixel_en      = pixel_en_q;
    assign DrawX         = x_q;
    assign DrawY         = y_q;
    assign line_start    = line_start_q;
    assign frame_start   = frame_start_q;
    assign hs            = pipe_q[PIPE_DEPTH-1][2];
    assign vs            = pipe_q[PIPE_DEPTH-1][1];
    assign active_nblank = pipe_q[PIPE_DEPTH-1][0];

endmodule
